// File: rtl/jk_cnt_pkg.sv
// jk_cnt_pkg
//   Shared definitions for the JK-cell modulus counter.
//   Exports the 2-bit mode encoding (jk_mode_t) and its four named values
//   so that the counter and any surrounding logic agree on what each mode
//   code means.
package jk_cnt_pkg;

  typedef logic [1:0] jk_mode_t;

  localparam jk_mode_t MODE_HOLD = 2'b00;
  localparam jk_mode_t MODE_UP   = 2'b01;
  localparam jk_mode_t MODE_DOWN = 2'b10;
  localparam jk_mode_t MODE_LOAD = 2'b11;

endpackage

// File: rtl/jk_cell.sv
// jk_cell
//   A single JK flip-flop with synchronous active-high reset.
//   Ports:
//     clk  in   rising-edge clock
//     rst  in   synchronous reset, active-high; forces q to 0
//     j    in   set request
//     k    in   reset request
//     q    out  registered flip-flop state
//   Behaviour: jk = 00 hold, 10 set, 01 reset, 11 toggle.
module jk_cell (
  input  logic clk,
  input  logic rst,
  input  logic j,
  input  logic k,
  output logic q
);

  always_ff @(posedge clk) begin
    if (rst) begin
      q <= 1'b0;
    end else begin
      case ({j, k})
        2'b10:   q <= 1'b1;
        2'b01:   q <= 1'b0;
        2'b11:   q <= ~q;
        default: q <= q;
      endcase
    end
  end

endmodule

// File: rtl/jk_mod_counter.sv
// jk_mod_counter
//   Synchronous up/down/load counter with range 0..MODULUS-1, built from a
//   bank of WIDTH JK flip-flop cells. The next count is chosen first and each
//   cell is then driven with J/K so that it moves straight to its next bit.
//   Parameters:
//     WIDTH    counter width in bits (>= 1)
//     MODULUS  count range 0..MODULUS-1, 2 <= MODULUS <= 2**WIDTH
//   Ports:
//     clk       in   rising-edge clock
//     rst       in   synchronous reset, active-high (q=0, ovf=0)
//     en        in   count enable; 0 holds regardless of mode
//     mode      in   00 HOLD, 01 UP, 10 DOWN, 11 LOAD
//     load_val  in   value loaded in LOAD mode (clamped to MODULUS-1)
//     q         out  current count, straight from the cells
//     tc        out  terminal count (combinational)
//     ovf       out  registered one-cycle pulse for a wrap (or blocked step)
//   Configuration macro:
//     JK_CNT_SATURATE_EN  when defined, UP at MODULUS-1 and DOWN at 0 hold q
//                         instead of wrapping; ovf still pulses to flag it.
module jk_mod_counter
  import jk_cnt_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int MODULUS = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] q,
  output logic             tc,
  output logic             ovf
);

  if (WIDTH < 1 || MODULUS < 2 || MODULUS > (2 ** WIDTH)) begin : g_bad_params
    $error("jk_mod_counter: illegal WIDTH/MODULUS combination");
  end

  // One spare bit so the load clamp and the +1/-1 results can be compared
  // against MODULUS-1 without aliasing.
  localparam logic [WIDTH:0]   MAX_V = (WIDTH + 1)'(MODULUS - 1);
  localparam logic [WIDTH-1:0] MAX_Q = MAX_V[WIDTH-1:0];

  logic [WIDTH:0]   q_wide;
  logic [WIDTH:0]   cand;
  logic [WIDTH-1:0] n;
  logic [WIDTH-1:0] j;
  logic [WIDTH-1:0] k;
  logic             at_max;
  logic             at_zero;
  logic             wrap;

  assign q_wide  = {1'b0, q};
  assign at_max  = (q_wide == MAX_V);
  assign at_zero = (q == '0);

  assign tc = en & (((mode == MODE_UP) & at_max) | ((mode == MODE_DOWN) & at_zero));

  // Next-value selection. The final clamp only ever bites on LOAD, since the
  // UP/DOWN paths already handle their bounds, but applying it to every
  // candidate guarantees q never leaves 0..MODULUS-1.
  always_comb begin
    cand = q_wide;
    wrap = 1'b0;
    if (en) begin
      case (mode)
        MODE_UP: begin
          if (at_max) begin
            wrap = 1'b1;
`ifdef JK_CNT_SATURATE_EN
            cand = q_wide;
`else
            cand = '0;
`endif
          end else begin
            cand = q_wide + 1'b1;
          end
        end
        MODE_DOWN: begin
          if (at_zero) begin
            wrap = 1'b1;
`ifdef JK_CNT_SATURATE_EN
            cand = q_wide;
`else
            cand = MAX_V;
`endif
          end else begin
            cand = q_wide - 1'b1;
          end
        end
        MODE_LOAD: cand = {1'b0, load_val};
        default:   cand = q_wide;
      endcase
    end
    if (cand > MAX_V) begin
      cand = MAX_V;
    end
  end

  assign n = (cand > MAX_V) ? MAX_Q : cand[WIDTH-1:0];

  // Drive each cell with set where the bit rises and reset where it falls;
  // J and K are mutually exclusive so the toggle case is never used.
  assign j = n & ~q;
  assign k = ~n & q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cells
    jk_cell u_cell (
      .clk (clk),
      .rst (rst),
      .j   (j[i]),
      .k   (k[i]),
      .q   (q[i])
    );
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ovf <= 1'b0;
    end else begin
      ovf <= wrap;
    end
  end

endmodule

// File: tb/tb_jk_mod_counter.sv
// tb_jk_mod_counter
//   Scoreboard bench for jk_mod_counter with WIDTH=4, MODULUS=10. The driver
//   applies one stimulus per cycle, queues the expected q/ovf/tc for that
//   cycle from an integer reference model, and a separate monitor pops and
//   compares on each falling edge. Directed sequences cover reset mid-count,
//   wrap up/down, load clamp, enable hold and mode switches at the bound,
//   followed by randomized traffic. Honours JK_CNT_SATURATE_EN in its model.
module tb_jk_mod_counter;
  import jk_cnt_pkg::*;

  localparam int WIDTH   = 4;
  localparam int MODULUS = 10;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             en = 1'b0;
  logic [1:0]       mode = MODE_HOLD;
  logic [WIDTH-1:0] load_val = '0;
  logic [WIDTH-1:0] q;
  logic             tc;
  logic             ovf;

  jk_mod_counter #(
    .WIDTH   (WIDTH),
    .MODULUS (MODULUS)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .mode     (mode),
    .load_val (load_val),
    .q        (q),
    .tc       (tc),
    .ovf      (ovf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    q;
    bit    ovf;
    bit    tc;
    string tag;
  } exp_t;

  exp_t  sbq[$];
  int    tests = 0;
  int    fails = 0;
  int    mq = 0;
  bit    movf = 1'b0;
  bit    model_valid = 1'b0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    tests++;
    if (actual != expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  // One cycle of stimulus. The expected entry describes what the monitor
  // should see during this cycle: the count produced by the previous edge
  // and the terminal-count for the inputs now applied.
  task automatic applyStimulus(input bit r, input bit e, input logic [1:0] m, input int lv,
                               input string tag);
    exp_t x;
    @(posedge clk);
    #1;
    rst      = r;
    en       = e;
    mode     = m;
    load_val = lv[WIDTH-1:0];
    if (model_valid) begin
      x.q   = mq;
      x.ovf = movf;
      x.tc  = e && ((m == MODE_UP && mq == MODULUS - 1) || (m == MODE_DOWN && mq == 0));
      x.tag = tag;
      sbq.push_back(x);
    end
    if (r) begin
      mq          = 0;
      movf        = 1'b0;
      model_valid = 1'b1;
    end else if (!e || m == MODE_HOLD) begin
      movf = 1'b0;
    end else if (m == MODE_UP) begin
      if (mq == MODULUS - 1) begin
        movf = 1'b1;
`ifndef JK_CNT_SATURATE_EN
        mq = 0;
`endif
      end else begin
        mq   = mq + 1;
        movf = 1'b0;
      end
    end else if (m == MODE_DOWN) begin
      if (mq == 0) begin
        movf = 1'b1;
`ifndef JK_CNT_SATURATE_EN
        mq = MODULUS - 1;
`endif
      end else begin
        mq   = mq - 1;
        movf = 1'b0;
      end
    end else begin
      mq   = (lv < MODULUS) ? lv : MODULUS - 1;
      movf = 1'b0;
    end
  endtask

  task automatic repeatStep(input int n, input bit e, input logic [1:0] m, input string tag);
    for (int i = 0; i < n; i++) begin
      applyStimulus(1'b0, e, m, 0, tag);
    end
  endtask

  initial begin : monitor
    exp_t x;
    forever begin
      @(negedge clk);
      if (sbq.size() > 0) begin
        x = sbq.pop_front();
        checkOutput($sformatf("%s q", x.tag), int'(q), x.q);
        checkOutput($sformatf("%s ovf", x.tag), int'(ovf), int'(x.ovf));
        checkOutput($sformatf("%s tc", x.tag), int'(tc), int'(x.tc));
        checkOutput($sformatf("%s q_in_range", x.tag), int'(int'(q) < MODULUS), 1);
        checkOutput($sformatf("%s jk_toggle", x.tag), int'(|(dut.j & dut.k)), 0);
      end
    end
  end

  initial begin : driver
    int r_lv;
    bit r_rst;
    bit r_en;
    logic [1:0] r_mode;

    // Reset mid-count
    applyStimulus(1'b1, 1'b0, MODE_HOLD, 0, "rst0");
    repeatStep(6, 1'b1, MODE_UP, "t1_up");
    applyStimulus(1'b1, 1'b1, MODE_UP, 0, "t1_rst");
    repeatStep(2, 1'b1, MODE_HOLD, "t1_hold");

    // Wrap up through MODULUS-1
    applyStimulus(1'b1, 1'b0, MODE_HOLD, 0, "t2_rst");
    repeatStep(11, 1'b1, MODE_UP, "t2_up");
    repeatStep(2, 1'b1, MODE_HOLD, "t2_hold");

    // Wrap down from 0
    applyStimulus(1'b0, 1'b1, MODE_LOAD, 0, "t3_load0");
    repeatStep(2, 1'b1, MODE_DOWN, "t3_down");
    repeatStep(2, 1'b1, MODE_HOLD, "t3_hold");

    // Load clamp, reload, disabled count
    applyStimulus(1'b0, 1'b1, MODE_LOAD, 13, "t4_load13");
    applyStimulus(1'b0, 1'b1, MODE_LOAD, 4, "t4_load4");
    repeatStep(3, 1'b0, MODE_UP, "t4_en0");
    applyStimulus(1'b0, 1'b1, MODE_LOAD, 15, "t4_load15");
    repeatStep(2, 1'b1, MODE_HOLD, "t4_hold");

    // Mode switch at the bound, then the saturating sequence
    applyStimulus(1'b0, 1'b1, MODE_LOAD, 9, "t5_load9");
    applyStimulus(1'b0, 1'b1, MODE_UP, 0, "t5_up");
    applyStimulus(1'b0, 1'b1, MODE_DOWN, 0, "t5_down");
    repeatStep(2, 1'b1, MODE_HOLD, "t5_hold");
    applyStimulus(1'b0, 1'b1, MODE_LOAD, 9, "t6_load9");
    repeatStep(3, 1'b1, MODE_UP, "t6_up");
    applyStimulus(1'b0, 1'b1, MODE_LOAD, 0, "t6_load0");
    repeatStep(2, 1'b1, MODE_DOWN, "t6_down");
    repeatStep(2, 1'b1, MODE_HOLD, "t6_hold");

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      r_rst  = ($urandom_range(0, 39) == 0);
      r_en   = ($urandom_range(0, 7) != 0);
      r_mode = 2'($urandom_range(0, 3));
      r_lv   = int'($urandom_range(0, 15));
      applyStimulus(r_rst, r_en, r_mode, r_lv, "rand");
    end
    applyStimulus(1'b0, 1'b1, MODE_HOLD, 0, "final");

    @(negedge clk);
    @(negedge clk);
    checkOutput("scoreboard_drained", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
